// File: rtl/dma_block_copy_pkg.sv
// Shared definitions for the DMA block copy engine: FSM states,
// config register map and CTRL bit positions.
package dma_block_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_WRITE,
    ST_YIELD,
    ST_DONE
  } dma_state_e;

  localparam logic [4:0] ADDR_SRC  = 5'b11000;
  localparam logic [4:0] ADDR_DST  = 5'b11001;
  localparam logic [4:0] ADDR_LEN  = 5'b11010;
  localparam logic [4:0] ADDR_CTRL = 5'b11011;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int LEN_W     = 16;
  localparam int MAX_BURST = 8;
  localparam int BURST_W   = 4;

endpackage

// File: rtl/dma_block_copy_cfg_regs.sv
// Software-visible SRC/DST/LEN registers plus the CTRL write decode
// that produces start/abort/clear pulses for the copy FSM.
module dma_cfg_regs
  import dma_block_copy_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [4:0]       addr_i,
  input  logic [31:0]      data_i,
  input  logic             busy_i,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             start_o,
  output logic             abort_o,
  output logic             clear_o
);

  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic             ctrlWrite;

  // Abort wins over start when both bits arrive in one write.
  assign ctrlWrite = we_i && (addr_i == ADDR_CTRL);
  assign abort_o   = ctrlWrite && data_i[CTRL_ABORT];
  assign start_o   = ctrlWrite && data_i[CTRL_START] && !data_i[CTRL_ABORT];
  assign clear_o   = ctrlWrite && data_i[CTRL_CLEAR];

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;

  // Pointer/length registers are frozen while a transfer is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (we_i && !busy_i) begin
      case (addr_i)
        ADDR_SRC: src_q <= {data_i[31:2], 2'b00};
        ADDR_DST: dst_q <= {data_i[31:2], 2'b00};
        ADDR_LEN: len_q <= data_i[LEN_W-1:0];
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/dma_block_copy.sv
// Bus-master block copy engine: requests the bus with hold, then copies
// words read-then-write in bursts, yielding the bus between bursts.
module dma_block_copy
  import dma_block_copy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] data_in,
  output logic        hold,
  input  logic        hold_ack,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        busy,
  output logic        done,
  output logic        irq
);

  dma_state_e         state_q;
  logic [31:0]        srcPtr_q;
  logic [31:0]        dstPtr_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [BURST_W-1:0] burst_q;
  logic [31:0]        buffer_q;
  logic               done_q;

  logic [31:0]        cfgSrc;
  logic [31:0]        cfgDst;
  logic [LEN_W-1:0]   cfgLen;
  logic               startPulse;
  logic               abortPulse;
  logic               clearPulse;

  dma_cfg_regs u_cfg (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .addr_i  (addr),
    .data_i  (data_in),
    .busy_i  (busy),
    .src_o   (cfgSrc),
    .dst_o   (cfgDst),
    .len_o   (cfgLen),
    .start_o (startPulse),
    .abort_o (abortPulse),
    .clear_o (clearPulse)
  );

  // Outputs decode straight from the state register; dm_we additionally
  // follows hold_ack so a write never reaches memory without the grant.
  assign hold     = (state_q == ST_REQ) || (state_q == ST_READ) || (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign dm_we    = (state_q == ST_WRITE) && hold_ack;
  assign dm_addr  = (state_q == ST_READ)  ? srcPtr_q :
                    (state_q == ST_WRITE) ? dstPtr_q : '0;
  assign dm_wdata = (state_q == ST_WRITE) ? buffer_q : '0;
  assign done     = done_q;
  assign irq      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      srcPtr_q <= '0;
      dstPtr_q <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
      buffer_q <= '0;
      done_q   <= 1'b0;
    end else begin
      if (clearPulse) done_q <= 1'b0;
      if (abortPulse && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (startPulse) begin
              if (cfgLen == '0) begin
                done_q <= 1'b1;
              end else begin
                srcPtr_q <= cfgSrc;
                dstPtr_q <= cfgDst;
                cnt_q    <= cfgLen;
                burst_q  <= '0;
                done_q   <= 1'b0;
                state_q  <= ST_REQ;
              end
            end
          end
          ST_REQ: begin
            if (hold_ack) state_q <= ST_READ;
          end
          ST_READ: begin
            if (hold_ack) begin
              buffer_q <= dm_rdata;
              state_q  <= ST_WRITE;
            end else begin
              state_q <= ST_REQ;
            end
          end
          // A lost grant here re-reads the same word; pointers only move on a committed write.
          ST_WRITE: begin
            if (!hold_ack) begin
              state_q <= ST_REQ;
            end else begin
              srcPtr_q <= srcPtr_q + 32'd4;
              dstPtr_q <= dstPtr_q + 32'd4;
              cnt_q    <= cnt_q - 1'b1;
              burst_q  <= burst_q + 1'b1;
              if (cnt_q == LEN_W'(1))
                state_q <= ST_DONE;
              else if (burst_q == BURST_W'(MAX_BURST - 1))
                state_q <= ST_YIELD;
              else
                state_q <= ST_READ;
            end
          end
          ST_YIELD: begin
            burst_q <= '0;
            state_q <= ST_REQ;
          end
          ST_DONE: begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_block_copy.sv
// Randomized scoreboard bench for dma_block_copy: a word-level copy model
// predicts every memory write, and a monitor checks them as they happen.
module tb_dma_block_copy;
  import dma_block_copy_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] data_in = '0;
  logic        hold;
  logic        hold_ack = 1'b0;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        busy;
  logic        done;
  logic        irq;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  logic [31:0] mem      [0:1023];
  logic [31:0] modelMem [0:1023];
  bit          memLoaded = 1'b0;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int ackMode = 0;
  int dropRequest = 0;
  int dropServed = 0;
  logic [31:0] dropAddr = 32'hFFFF_FFFF;
  logic holdSeen = 1'b0;
  logic donePrev = 1'b0;

  int totalWrites = 0;
  int holdLowBusy = 0;
  int holdHighCycles = 0;
  int firstLowWrites = 0;
  int dropWrites = 0;
  int doneRiseCycle = 0;
  logic [31:0] lastWrAddr = '0;

  int writeBase = 0;
  int lowBase = 0;
  int holdHighBase = 0;
  int dropBase = 0;
  int startCycle = 0;
  int curLen = 0;
  logic [31:0] curDst = '0;

  dma_block_copy dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .hold     (hold),
    .hold_ack (hold_ack),
    .dm_addr  (dm_addr),
    .dm_we    (dm_we),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .busy     (busy),
    .done     (done),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // 4 KB data memory that aliases the 32-bit address space.
  assign dm_rdata = mem[dm_addr[11:2]];
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
      memLoaded <= 1'b1;
    end else if (dm_we) begin
      mem[dm_addr[11:2]] <= dm_wdata;
    end
  end

  always @(negedge clk) holdSeen = hold;

  // Grant models: 0 permanent, 1 hold delayed one cycle, 2 random, 3 permanent with one drop.
  always @(posedge clk) begin
    #1;
    case (ackMode)
      1: hold_ack = holdSeen;
      2: hold_ack = ($urandom_range(0, 3) != 0);
      3: begin
        if (dropServed != dropRequest && hold && dm_addr == dropAddr) begin
          hold_ack = 1'b0;
          dropServed = dropRequest;
        end else begin
          hold_ack = 1'b1;
        end
      end
      default: hold_ack = 1'b1;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (done && !donePrev) doneRiseCycle = cycle;
    donePrev = done;
    if (hold) holdHighCycles++;
    if (busy && !hold) begin
      if (holdLowBusy == lowBase) firstLowWrites = totalWrites;
      holdLowBusy++;
    end
    if (!rst && dm_we) begin
      checkOutput("we_needs_ack", hold_ack, 1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", dm_we, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", dm_addr, e.addr);
        checkOutput("wr_data", dm_wdata, e.data);
      end
      totalWrites++;
      lastWrAddr = dm_addr;
      if (dm_addr == dropAddr) dropWrites++;
    end
  end

  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    we = 1'b1;
    addr = a;
    data_in = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    addr = '0;
    data_in = '0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_hold"}, hold, 0);
    checkOutput({tag, "_dm_we"}, dm_we, 0);
    checkOutput({tag, "_dm_addr"}, dm_addr, 0);
    checkOutput({tag, "_dm_wdata"}, dm_wdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_irq"}, irq, 0);
  endtask

  // Predict the write stream of an ascending word copy on a snapshot of memory.
  task automatic startCopy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input int mode, input bit writeRegs);
    logic [31:0] sa;
    logic [31:0] da;
    logic [31:0] v;
    wr_t w;
    if (writeRegs) begin
      applyStimulus(ADDR_SRC, s);
      applyStimulus(ADDR_DST, d);
      applyStimulus(ADDR_LEN, l);
    end
    applyStimulus(ADDR_CTRL, 32'h4);
    @(negedge clk);
    checkOutput("done_cleared", done, 0);
    ackMode = mode;
    if (mode == 3) begin
      dropAddr = (d & 32'hFFFF_FFFC) + 32'd4;
      dropRequest++;
    end
    curLen = int'(l[15:0]);
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    curDst = da;
    modelMem = mem;
    expQ.delete();
    for (int i = 0; i < curLen; i++) begin
      v = modelMem[sa[11:2]];
      modelMem[da[11:2]] = v;
      w.addr = da;
      w.data = v;
      expQ.push_back(w);
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
    writeBase = totalWrites;
    lowBase = holdLowBusy;
    holdHighBase = holdHighCycles;
    dropBase = dropWrites;
    applyStimulus(ADDR_CTRL, 32'h1);
    startCycle = cycle;
  endtask

  task automatic waitWrites(input int n);
    for (int c = 0; c < 2000 && (totalWrites - writeBase) < n; c++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("reach_writes", totalWrites - writeBase, n);
  endtask

  task automatic finishCopy(input int mode);
    bit got;
    int expLat;
    int expFirst;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) got = 1'b1;
    end
    checkOutput("done_seen", done, 1);
    checkOutput("irq_after", irq, 1);
    checkOutput("hold_after", hold, 0);
    checkOutput("busy_after", busy, 0);
    checkOutput("write_count", totalWrites - writeBase, curLen);
    checkOutput("pending_writes", expQ.size(), 0);
    checkOutput("hold_low_busy_cycles", holdLowBusy - lowBase, (curLen + MAX_BURST - 1) / MAX_BURST);
    if (curLen > 0) begin
      expFirst = (curLen < MAX_BURST) ? curLen : MAX_BURST;
      checkOutput("first_hold_low_after", firstLowWrites - writeBase, expFirst);
      checkOutput("last_dst", lastWrAddr, curDst + 32'(4 * (curLen - 1)));
    end else begin
      checkOutput("len0_hold_cycles", holdHighCycles - holdHighBase, 0);
    end
    if (mode == 0) begin
      expLat = (curLen == 0) ? 0 : 2 + 2 * curLen + 2 * ((curLen + MAX_BURST - 1) / MAX_BURST - 1);
      checkOutput("latency", doneRiseCycle - startCycle, expLat);
    end
    if (mode == 3) begin
      checkOutput("drop_fired", dropServed, dropRequest);
      checkOutput("dropped_word_writes", dropWrites - dropBase, 1);
    end
  endtask

  initial begin
    logic [31:0] rs;
    logic [31:0] rd;
    logic [31:0] rl;
    int rm;

    repeat (3) @(negedge clk);
    checkIdle("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    $display("[TB] basic copy with delayed grant");
    startCopy(32'h100, 32'h200, 32'd3, 1, 1'b1);
    finishCopy(1);

    $display("[TB] zero-length start");
    startCopy(32'h100, 32'h200, 32'd0, 0, 1'b1);
    finishCopy(0);

    $display("[TB] ten words with a yield, config writes while busy");
    startCopy(32'h400, 32'h600, {16'hBEEF, 16'd10}, 0, 1'b1);
    waitWrites(1);
    applyStimulus(ADDR_SRC, 32'h0000_0A00);
    applyStimulus(ADDR_LEN, 32'd2);
    finishCopy(0);
    startCopy(32'h400, 32'h600, 32'd10, 0, 1'b0);
    finishCopy(0);

    $display("[TB] grant dropped during second write");
    startCopy(32'h100, 32'h200, 32'd5, 3, 1'b1);
    finishCopy(3);

    $display("[TB] abort during fourth word");
    startCopy(32'h140, 32'h240, 32'd8, 0, 1'b1);
    waitWrites(3);
    applyStimulus(ADDR_CTRL, 32'h3);
    @(negedge clk);
    checkOutput("abort_hold", hold, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_pending", expQ.size(), 5);
    expQ.delete();
    repeat (5) @(negedge clk);
    checkOutput("abort_writes", totalWrites - writeBase, 3);
    checkOutput("abort_done", done, 0);
    startCopy(32'h500, 32'h700, 32'd4, 0, 1'b1);
    finishCopy(0);

    $display("[TB] reset mid-transfer");
    startCopy(32'h180, 32'h280, 32'd6, 0, 1'b1);
    waitWrites(2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkIdle("mid_reset");
    expQ.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    startCopy(32'h1C0, 32'h2C0, 32'd4, 0, 1'b1);
    finishCopy(0);

    $display("[TB] overlapping ranges and address wrap");
    startCopy(32'h300, 32'h308, 32'd6, 0, 1'b1);
    finishCopy(0);
    startCopy(32'hFFFF_FFF6, 32'h0000_0F03, 32'd6, 0, 1'b1);
    finishCopy(0);

    $display("[TB] randomized copies");
    for (int t = 0; t < 8; t++) begin
      rs = $urandom;
      rd = $urandom;
      rl = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(1, 20));
      rm = $urandom_range(0, 2);
      startCopy(rs, rd, rl, rm, 1'b1);
      finishCopy(rm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
